// File: rtl/gemm_pkg.sv
// +----------------------------------------------------------------------------+
// | gemm_pkg : shared state encoding and width helpers for gemm_engine          |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package gemm_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_STORE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   // Sum of K full-width products never exceeds this width.
   function automatic int acc_width(input int dw, input int k);
      return 2 * dw + clog2(k + 1);
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage : gemm_pkg

`default_nettype wire

// File: rtl/gemm_mac.sv
// +----------------------------------------------------------------------------+
// | gemm_mac : operand register, signed/unsigned multiply, clearable accumulator|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gemm_mac
   import gemm_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SIGNED = 0,
   parameter int ACC_W  = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              op_vld_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [ACC_W-1:0]  acc_o
);

   localparam int PW = 2 * DATA_W;

   logic [DATA_W-1:0] a_q, b_q;
   logic              vld_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  prod_ext;

   generate
      if (SIGNED != 0) begin : g_signed
         logic signed [PW-1:0] prod;
         assign prod     = PW'($signed(a_q)) * PW'($signed(b_q));
         assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
      end else begin : g_unsigned
         logic [PW-1:0] prod;
         assign prod     = PW'(a_q) * PW'(b_q);
         assign prod_ext = {{(ACC_W-PW){1'b0}}, prod};
      end
   endgenerate

   assign acc_d = vld_q ? (acc_q + prod_ext) : acc_q;
   assign acc_o = acc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         vld_q <= 1'b0;
         acc_q <= '0;
      end else if (clr_i) begin
         vld_q <= 1'b0;
         acc_q <= '0;
      end else begin
         a_q   <= a_i;
         b_q   <= b_i;
         vld_q <= op_vld_i;
         acc_q <= acc_d;
      end
   end

endmodule : gemm_mac

`default_nettype wire

// File: rtl/gemm_engine.sv
// +----------------------------------------------------------------------------+
// | gemm_engine : R = A x B matrix engine with A/B load port and R read port    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gemm_engine
   import gemm_pkg::*;
#(
   parameter int M      = 2,
   parameter int K      = 2,
   parameter int N      = 2,
   parameter int DATA_W = 8,
   parameter int SIGNED = 0,
   parameter int ACC_W  = acc_width(DATA_W, K),
   parameter int ADDR_W = clog2(max3(M*K, K*N, M*N) + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic              wr_sel_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [ACC_W-1:0]  rd_data_o,
   output logic              rd_valid_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int IW    = cnt_width(M);
   localparam int JW    = cnt_width(N);
   localparam int KW    = cnt_width(K);

   state_t            state_q;
   logic [IW-1:0]     i_q;
   logic [JW-1:0]     j_q;
   logic [KW-1:0]     k_q;
   logic              busy_q, done_q;
   logic [ACC_W-1:0]  rd_data_q;
   logic              rd_valid_q;

   logic [DATA_W-1:0] mem_a_q [DEPTH];
   logic [DATA_W-1:0] mem_b_q [DEPTH];
   logic [ACC_W-1:0]  mem_r_q [DEPTH];

   logic [ADDR_W-1:0] a_idx, b_idx, r_idx;
   logic              wr_ok, mac_clr, mac_vld;
   logic [ACC_W-1:0]  acc;

   assign a_idx   = ADDR_W'(i_q) * ADDR_W'(K) + ADDR_W'(k_q);
   assign b_idx   = ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
   assign r_idx   = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
   assign wr_ok   = wr_en_i && (state_q == ST_IDLE);
   assign mac_vld = (state_q == ST_RUN);
   assign mac_clr = (state_q == ST_STORE) || ((state_q == ST_IDLE) && start_i);

   gemm_mac #(
      .DATA_W (DATA_W),
      .SIGNED (SIGNED),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (mac_clr),
      .op_vld_i (mac_vld),
      .a_i      (mem_a_q[a_idx]),
      .b_i      (mem_b_q[b_idx]),
      .acc_o    (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  i_q     <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (k_q == KW'(K-1)) state_q <= ST_DRAIN;
               else                 k_q     <= k_q + KW'(1);
            end
            ST_DRAIN: state_q <= ST_STORE;
            ST_STORE: begin
               k_q <= '0;
               if (j_q == JW'(N-1)) begin
                  j_q <= '0;
                  if (i_q == IW'(M-1)) begin
                     i_q     <= '0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     i_q     <= i_q + IW'(1);
                     state_q <= ST_RUN;
                  end
               end else begin
                  j_q     <= j_q + JW'(1);
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Load port is only open in IDLE; out-of-range addresses are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < DEPTH; n++) begin
            mem_a_q[n] <= '0;
            mem_b_q[n] <= '0;
         end
      end else if (wr_ok) begin
         if (!wr_sel_i && (wr_addr_i < ADDR_W'(M*K))) mem_a_q[wr_addr_i] <= wr_data_i;
         if ( wr_sel_i && (wr_addr_i < ADDR_W'(K*N))) mem_b_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < DEPTH; n++) mem_r_q[n] <= '0;
      end else if (state_q == ST_STORE) begin
         mem_r_q[r_idx] <= acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en_i;
         if (rd_en_i) begin
            if ((state_q != ST_IDLE) || (rd_addr_i >= ADDR_W'(M*N))) rd_data_q <= '0;
            else                                                     rd_data_q <= mem_r_q[rd_addr_i];
         end
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;

endmodule : gemm_engine

`default_nettype wire

// File: tb/tb_gemm_engine.sv
// +----------------------------------------------------------------------------+
// | tb_gemm_engine : directed scoreboard bench for three gemm_engine configs    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gemm_engine;

   localparam int AW = 3;
   localparam int RW = 18;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [2:0]        wr_en = '0;
   logic [2:0]        start = '0;
   logic [2:0]        rd_en = '0;
   logic              wr_sel = 1'b0;
   logic [AW-1:0]     wr_addr = '0;
   logic [AW-1:0]     rd_addr = '0;
   logic [7:0]        wr_data = '0;
   logic [2:0]        busy, done, rd_valid;
   logic [RW-1:0]     rd_data [3];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int            d;
      logic [RW-1:0] v;
      string         name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   gemm_engine #(.M(2), .K(2), .N(2), .DATA_W(8), .SIGNED(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en[0]), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
      .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]));

   gemm_engine #(.M(2), .K(3), .N(1), .DATA_W(8), .SIGNED(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en[1]), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
      .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]));

   gemm_engine #(.M(2), .K(2), .N(2), .DATA_W(8), .SIGNED(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en[2]), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr),
      .wr_data_i(wr_data), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
      .rd_en_i(rd_en[2]), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]));

   // Monitor: every rd_valid pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (rd_valid[d]) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_read dut%0d: rd_data=%0d, no read was expected", d, rd_data[d]);
               end else begin
                  e = sb.pop_front();
                  if (e.d != d || rd_data[d] !== e.v) begin
                     failures++;
                     $display("FAIL %s dut%0d: got 0x%05h, expected 0x%05h from dut%0d",
                              e.name, d, rd_data[d], e.v, e.d);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int d, input bit sel, input int addr, input int val);
      wr_en[d] = 1'b1;
      wr_sel   = sel;
      wr_addr  = AW'(addr);
      wr_data  = 8'(val);
      tick();
      wr_en    = '0;
   endtask

   task automatic load(input int d, input int a[6], input int na, input int b[6], input int nb);
      for (int n = 0; n < na; n++) wr(d, 1'b0, n, a[n]);
      for (int n = 0; n < nb; n++) wr(d, 1'b1, n, b[n]);
   endtask

   task automatic rd(input int d, input int addr, input int val, input string nm);
      rd_addr  = AW'(addr);
      rd_en[d] = 1'b1;
      sb.push_back('{d, RW'(val), nm});
      tick();
      rd_en    = '0;
   endtask

   // Caller may pre-drive a write to coincide with start.
   task automatic run_timed(input int d, input int exp_edges, input bit poke);
      int cnt;
      bit got;
      cnt = 0;
      got = 1'b0;
      start[d] = 1'b1;
      while (!got && cnt < 300) begin
         @(posedge clk);
         cnt++;
         #1;
         if (done[d]) got = 1'b1;
         if (cnt == 1) begin
            start = '0;
            wr_en = '0;
            chk("busy_after_start", 64'(busy[d]), 64'd1);
         end
         if (poke && cnt == 5) begin
            start[d] = 1'b1;
            wr_en[d] = 1'b1;
            wr_sel   = 1'b0;
            wr_addr  = '0;
            wr_data  = 8'd99;
            rd_en[d] = 1'b1;
            rd_addr  = AW'(3);
            sb.push_back('{d, '0, "rd_while_busy"});
         end
         if (poke && cnt == 6) begin
            start = '0;
            wr_en = '0;
            rd_en = '0;
         end
      end
      chk("done_edge_count", got ? 64'(cnt) : 64'd0, 64'(exp_edges));
      tick();
      chk("busy_done_fall", 64'({busy[d], done[d]}), 64'd0);
   endtask

   initial begin
      int  a[6];
      int  b[6];
      bit  seen;

      repeat (3) tick();
      for (int d = 0; d < 3; d++) begin
         chk("reset_flags", 64'({busy[d], done[d], rd_valid[d]}), 64'd0);
         chk("reset_rd_data", 64'(rd_data[d]), 64'd0);
      end
      rst_n = 1'b1;
      tick();

      // Abort a run with an asynchronous reset pulse.
      a = '{1, 2, 3, 4, 0, 0};
      b = '{5, 6, 7, 8, 0, 0};
      load(0, a, 4, b, 4);
      start[0] = 1'b1;
      tick();
      start = '0;
      repeat (3) tick();
      chk("busy_mid_run", 64'(busy[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("reset_abort_flags", 64'({busy[0], done[0]}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (done[0]) seen = 1'b1;
      end
      chk("no_done_after_reset", 64'(seen), 64'd0);
      for (int n = 0; n < 4; n++) rd(0, n, 0, "r_cleared_by_reset");

      // Fresh load; last B element written in the same cycle as start.
      load(0, a, 4, b, 3);
      wr_en[0] = 1'b1;
      wr_sel   = 1'b1;
      wr_addr  = AW'(3);
      wr_data  = 8'd8;
      run_timed(0, 17, 1'b1);
      rd(0, 0, 19, "u2x2_r00");
      rd(0, 1, 22, "u2x2_r01");
      rd(0, 2, 43, "u2x2_r10");
      rd(0, 3, 50, "u2x2_r11");
      tick();
      tick();
      chk("rd_data_hold", 64'(rd_data[0]), 64'd50);
      rd(0, 7, 0, "rd_out_of_range");

      // 2x3 * 3x1 at full scale: no truncation.
      a = '{255, 255, 255, 1, 2, 3};
      b = '{255, 255, 255, 0, 0, 0};
      load(1, a, 6, b, 3);
      run_timed(1, 11, 1'b0);
      rd(1, 0, 195075, "k3_r0");
      rd(1, 1, 1530, "k3_r1");
      rd(1, 2, 0, "k3_out_of_range");

      // Signed two's-complement operands.
      a = '{-1, 2, -128, 127, 0, 0};
      b = '{3, -4, -128, 1, 0, 0};
      load(2, a, 4, b, 4);
      run_timed(2, 17, 1'b0);
      rd(2, 0, -259, "s2x2_r00");
      rd(2, 1, 6, "s2x2_r01");
      rd(2, 2, -16640, "s2x2_r10");
      rd(2, 3, 639, "s2x2_r11");

      repeat (3) tick();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_gemm_engine

`default_nettype wire
